// File: rtl/spi_encoder_master_if.sv
// Handshake, snapshot and SPI pin bundle for spi_encoder_master.
// deltaA/deltaB exist only when SPI_ENC_DELTA_EN is defined.
interface spi_encoder_master_if;
   logic        start;
   logic        busy;
   logic        done;
   logic [15:0] countA;
   logic [15:0] countB;
   logic        csN;
   logic        sck;
   logic        mosi;
   logic        miso;
`ifdef SPI_ENC_DELTA_EN
   logic signed [15:0] deltaA;
   logic signed [15:0] deltaB;
`endif

   modport master (
      input  start, miso,
      output busy, done, countA, countB, csN, sck, mosi
`ifdef SPI_ENC_DELTA_EN
      , output deltaA, deltaB
`endif
   );

   modport slave (
      output start, miso,
      input  busy, done, countA, countB, csN, sck, mosi
`ifdef SPI_ENC_DELTA_EN
      , input deltaA, deltaB
`endif
   );
endinterface

// File: rtl/spi_encoder_master.sv
// SPI mode-0 initiator reading two 16-bit encoder counts in one 5-byte frame.
// Optional SPI_ENC_DELTA_EN adds signed count deltas loaded with each snapshot.
module spi_encoder_master #(
   parameter int CLK_DIV  = 4,
   parameter int CS_SETUP = 2,
   parameter int CS_HOLD  = 2
) (
   input logic                  clk,
   input logic                  reset,
   spi_encoder_master_if.master bus
);

   // Read addresses 0..3 followed by one dummy byte that clocks out the last reply.
   localparam logic [39:0] TX_FRAME = 40'h00_01_02_03_00;
   localparam int          NHALF    = 80;

   typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

   state_t      state;
   logic [15:0] tmr;
   logic [6:0]  half;
   logic [39:0] tx_sh;
   // Only the last 32 received bits matter; reply byte 0 falls off the top.
   logic [31:0] rx_sh;

`ifdef SPI_ENC_DELTA_EN
   function automatic logic signed [15:0] wrap_delta(input logic [15:0] cur,
                                                    input logic [15:0] prev);
      wrap_delta = signed'(cur - prev);
   endfunction
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         tmr        <= '0;
         half       <= '0;
         tx_sh      <= '0;
         rx_sh      <= '0;
         bus.csN    <= 1'b1;
         bus.sck    <= 1'b0;
         bus.mosi   <= 1'b0;
         bus.busy   <= 1'b0;
         bus.done   <= 1'b0;
         bus.countA <= '0;
         bus.countB <= '0;
`ifdef SPI_ENC_DELTA_EN
         bus.deltaA <= '0;
         bus.deltaB <= '0;
`endif
      end else begin
         bus.done <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  state    <= SETUP;
                  bus.busy <= 1'b1;
                  bus.csN  <= 1'b0;
                  bus.mosi <= TX_FRAME[39];
                  tx_sh    <= {TX_FRAME[38:0], 1'b0};
                  tmr      <= '0;
               end
            end
            SETUP: begin
               if (tmr == 16'(CS_SETUP - 1)) begin
                  state   <= SHIFT;
                  bus.sck <= 1'b1;
                  rx_sh   <= {rx_sh[30:0], bus.miso};
                  tmr     <= '0;
                  half    <= '0;
               end else begin
                  tmr <= tmr + 16'd1;
               end
            end
            SHIFT: begin
               // Half 0 is high, so the final half (79) ends with sck already low.
               if (tmr == 16'(CLK_DIV - 1)) begin
                  tmr <= '0;
                  if (half == 7'(NHALF - 1)) begin
                     state <= HOLD;
                  end else begin
                     half    <= half + 7'd1;
                     bus.sck <= ~bus.sck;
                     if (bus.sck) begin
                        bus.mosi <= tx_sh[39];
                        tx_sh    <= {tx_sh[38:0], 1'b0};
                     end else begin
                        rx_sh <= {rx_sh[30:0], bus.miso};
                     end
                  end
               end else begin
                  tmr <= tmr + 16'd1;
               end
            end
            HOLD: begin
               if (tmr == 16'(CS_HOLD - 1)) begin
                  state      <= IDLE;
                  bus.csN    <= 1'b1;
                  bus.busy   <= 1'b0;
                  bus.done   <= 1'b1;
                  bus.mosi   <= 1'b0;
                  bus.countA <= rx_sh[31:16];
                  bus.countB <= rx_sh[15:0];
`ifdef SPI_ENC_DELTA_EN
                  bus.deltaA <= wrap_delta(rx_sh[31:16], bus.countA);
                  bus.deltaB <= wrap_delta(rx_sh[15:0], bus.countB);
`endif
               end else begin
                  tmr <= tmr + 16'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
